// File: rtl/ena_scheduler_pkg.sv
// ena_scheduler_pkg: shared FSM encodings, LFSR mask and ENA_NONE helper for the ena scheduler
package ena_scheduler_pkg;
   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_RUN      = 2'd1;
   localparam logic [1:0] S_DEADLOCK = 2'd2;
   localparam logic [15:0] LFSR_MASK = 16'hB400;
   function automatic int ena_none(input int ntrans);
      return ntrans + 1;
   endfunction
endpackage

// File: rtl/ena_scheduler_if.sv
// ena_scheduler_if: circuit-side control inputs and the ena select bus driven by the scheduler
interface ena_scheduler_if #(
   parameter int NTRANS = 8,
   parameter int EW     = $clog2(NTRANS + 2)
) ();
   logic              run;
   logic [NTRANS-1:0] excited;
   logic              force_valid;
   logic [EW-1:0]     force_idx;
   logic [EW-1:0]     ena;
   logic              deadlock;
   logic [31:0]       steps;
   modport master (output run, excited, force_valid, force_idx, input ena, deadlock, steps);
   modport slave (input run, excited, force_valid, force_idx, output ena, deadlock, steps);
endinterface

// File: rtl/ena_scheduler_rr_pick.sv
// ena_scheduler_rr_pick: first set request at or after start, searching upward with wrap
module ena_scheduler_rr_pick #(
   parameter int N = 8
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] start_i,
   output logic                 hit_o,
   output logic [$clog2(N)-1:0] idx_o
);
   logic [2*N-1:0] dbl;
   // rotate so start sits at bit 0, then take the lowest set bit of the rotated view
   always_comb begin
      dbl   = {req_i, req_i} >> start_i;
      hit_o = 1'b0;
      idx_o = '0;
      for (int k = N - 1; k >= 0; k--)
         if (dbl[k]) begin
            hit_o = 1'b1;
            idx_o = $clog2(N)'((int'(start_i) + k) % N);
         end
   end
endmodule

// File: rtl/ena_scheduler.sv
// ena_scheduler: picks one excited transition per cycle (forced, starved-first, else random) and flags deadlock
module ena_scheduler
   import ena_scheduler_pkg::*;
#(
   parameter int          NTRANS         = 8,
   parameter int          EW             = $clog2(NTRANS + 2),
   parameter logic [15:0] LFSR_SEED      = 16'hACE1,
   parameter int          STARVE_LIMIT   = 16,
   parameter int          DEADLOCK_LIMIT = 64
) (
   input logic         clk,
   input logic         reset,
   ena_scheduler_if.slave bus
);
   localparam int IW = $clog2(NTRANS);
   localparam int AW = $clog2(STARVE_LIMIT + 1);
   localparam int SW = $clog2(DEADLOCK_LIMIT + 1);
   localparam logic [EW-1:0] NONE = EW'(ena_none(NTRANS));
   localparam logic [15:0]   SEED = (LFSR_SEED == 16'd0) ? 16'd1 : LFSR_SEED;

   logic [1:0]        state_q, state_d;
   logic [15:0]       lfsr_q, lfsr_d;
   logic [SW-1:0]     stall_q, stall_d;
   logic [AW-1:0]     age_q [NTRANS];
   logic [AW-1:0]     age_d [NTRANS];
   logic [EW-1:0]     ena_q, ena_d;
   logic [31:0]       steps_q, steps_d;
   logic [NTRANS-1:0] starve;
   logic [IW-1:0]     start, s_idx, r_idx, pick;
   logic              force_ok, s_hit, r_hit, active;

   ena_scheduler_rr_pick #(.N(NTRANS)) u_starve (.req_i(starve), .start_i('0), .hit_o(s_hit), .idx_o(s_idx));
   ena_scheduler_rr_pick #(.N(NTRANS)) u_rand (.req_i(bus.excited), .start_i(start), .hit_o(r_hit), .idx_o(r_idx));

   // policy selection: a valid excited force wins, then the lowest starved transition, then the random rotation
   always_comb begin
      starve = '0;
      for (int i = 0; i < NTRANS; i++)
         starve[i] = bus.excited[i] && (age_q[i] >= AW'(STARVE_LIMIT));
      force_ok = bus.force_valid && (bus.force_idx < EW'(NTRANS)) &&
                 |(bus.excited & (NTRANS'(1) << bus.force_idx));
      start    = IW'(lfsr_q % 16'(NTRANS));
      pick     = force_ok ? bus.force_idx[IW-1:0] : s_hit ? s_idx : r_idx;
      active   = (state_q == S_RUN) && bus.run;
   end

   // next state: everything except the FSM itself is frozen unless running in S_RUN
   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      stall_d = stall_q;
      ena_d   = NONE;
      steps_d = steps_q;
      age_d   = age_q;
      if (state_q == S_IDLE && bus.run) state_d = S_RUN;
      if (state_q == S_RUN && !bus.run) state_d = S_IDLE;
      if (active) begin
         lfsr_d  = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
         ena_d   = r_hit ? EW'(pick) : NONE;
         steps_d = steps_q + 32'(r_hit);
         stall_d = r_hit ? '0 : stall_q + 1'b1;
         if (!r_hit && (stall_q + 1'b1) == SW'(DEADLOCK_LIMIT)) state_d = S_DEADLOCK;
         for (int i = 0; i < NTRANS; i++)
            age_d[i] = (!bus.excited[i] || (r_hit && pick == IW'(i))) ? '0 :
                       (&age_q[i]) ? age_q[i] : age_q[i] + 1'b1;
      end
   end

   // state registers, all returning to reset values immediately on reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         lfsr_q  <= SEED;
         stall_q <= '0;
         ena_q   <= NONE;
         steps_q <= '0;
         for (int i = 0; i < NTRANS; i++) age_q[i] <= '0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         stall_q <= stall_d;
         ena_q   <= ena_d;
         steps_q <= steps_d;
         age_q   <= age_d;
      end
   end

   assign bus.ena      = ena_q;
   assign bus.deadlock = (state_q == S_DEADLOCK);
   assign bus.steps    = steps_q;
endmodule

// File: tb/tb_ena_scheduler.sv
// tb_ena_scheduler: directed checks of reset, deadlock, force, starvation, fairness and run gating
module tb_ena_scheduler;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int vectors = 0;
   int miscompares = 0;

   ena_scheduler_if #(.NTRANS(8), .EW(4)) bus ();
   ena_scheduler dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic restart(input logic [7:0] exc, input logic fv, input logic [3:0] fi);
      reset = 1'b1;
      #1;
      chk("async_rst_ena", 32'(bus.ena), 9);
      chk("async_rst_steps", bus.steps, 0);
      bus.run = 1'b1;
      bus.excited = exc;
      bus.force_valid = fv;
      bus.force_idx = fi;
      tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      int seen0, seen7, last0, last7, gap, bad_rng, bad_stab;
      logic [3:0] n;
      bus.run = 1'b1;
      bus.excited = 8'hFF;
      bus.force_valid = 1'b0;
      bus.force_idx = '0;
      tick(2);
      chk("rst_ena", 32'(bus.ena), 9);
      chk("rst_dead", 32'(bus.deadlock), 0);
      chk("rst_steps", bus.steps, 0);
      reset = 1'b0;
      tick();
      chk("idle_to_run_ena", 32'(bus.ena), 9);
      tick();
      chk("first_pick_range", 32'(bus.ena < 8), 1);
      chk("first_pick_steps", bus.steps, 1);

      restart(8'h00, 1'b0, 4'd0);
      chk("dl_run_ena", 32'(bus.ena), 9);
      for (int c = 1; c <= 64; c++) begin
         tick();
         chk("dl_ena", 32'(bus.ena), 9);
         if (c == 63) chk("dl_before", 32'(bus.deadlock), 0);
         if (c == 64) chk("dl_at64", 32'(bus.deadlock), 1);
      end
      bus.excited = 8'hFF;
      tick(5);
      chk("dl_sticky", 32'(bus.deadlock), 1);
      chk("dl_sticky_ena", 32'(bus.ena), 9);
      chk("dl_steps", bus.steps, 0);

      restart(8'h20, 1'b1, 4'd5);
      tick();
      chk("force5_only", 32'(bus.ena), 5);
      bus.excited = 8'hFF;
      tick();
      chk("force5_all", 32'(bus.ena), 5);
      bus.excited = 8'h24;
      bus.force_idx = 4'd9;
      tick();
      chk("force9_ignored", 32'(bus.ena == 2 || bus.ena == 5), 1);
      bus.force_valid = 1'b1;
      bus.force_idx = 4'd0;
      tick();
      chk("force_not_excited", 32'(bus.ena == 2 || bus.ena == 5), 1);

      restart(8'h03, 1'b1, 4'd0);
      for (int c = 1; c <= 17; c++) begin
         tick();
         chk("force_over_starve", 32'(bus.ena), 0);
      end
      bus.force_valid = 1'b0;
      tick();
      chk("starve_pick1", 32'(bus.ena), 1);

      bus.excited = 8'h81;
      seen0 = 0; seen7 = 0; last0 = 0; last7 = 0; gap = 0; bad_rng = 0; bad_stab = 0;
      for (int c = 1; c <= 1000; c++) begin
         @(negedge clk);
         n = bus.ena;
         if (n > 9) bad_rng++;
         if (n == 0) begin seen0++; if (c - last0 > gap) gap = c - last0; last0 = c; end
         if (n == 7) begin seen7++; if (c - last7 > gap) gap = c - last7; last7 = c; end
         #4;
         if (bus.ena !== n) bad_stab++;
      end
      tick();
      chk("rand_seen0", 32'(seen0 > 0), 1);
      chk("rand_seen7", 32'(seen7 > 0), 1);
      chk("rand_maxgap_le17", 32'(gap <= 17), 1);
      chk("rand_range", 32'(bad_rng), 0);
      chk("rand_stable", 32'(bad_stab), 0);

      restart(8'hFF, 1'b0, 4'd0);
      tick(5);
      chk("run_steps5", bus.steps, 5);
      bus.excited = 8'h00;
      tick(40);
      chk("run_stall_ena", 32'(bus.ena), 9);
      bus.run = 1'b0;
      bus.excited = 8'hFF;
      for (int c = 1; c <= 10; c++) begin
         tick();
         chk("off_ena", 32'(bus.ena), 9);
      end
      chk("off_steps", bus.steps, 5);
      bus.run = 1'b1;
      bus.excited = 8'h00;
      tick(24);
      chk("resume_no_dl", 32'(bus.deadlock), 0);
      tick();
      chk("resume_dl_held_stall", 32'(bus.deadlock), 1);
      chk("resume_steps", bus.steps, 5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
